// File: rtl/eth_phy_10g_rx_block_lock_ctrl.sv
// 10GBASE-R receive block-lock state machine: tracks sync headers, raises lock, requests bitslips.
// Optional RX_LOCK_STATS_EN macro adds saturating bitslip and lock-loss counters.
module eth_phy_10g_rx_block_lock_ctrl #(
    parameter int unsigned HDR_WIDTH        = 2,
    parameter int unsigned LOCK_CNT         = 64,
    parameter int unsigned ERR_LIMIT        = 16,
    parameter int unsigned SLIP_WAIT_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HDR_WIDTH-1:0] i_serdes_rx_hdr,
    input  logic                 i_serdes_rx_hdr_valid,
`ifdef RX_LOCK_STATS_EN
    output logic [15:0]          o_slip_cnt,
    output logic [15:0]          o_lock_loss_cnt,
`endif
    output logic                 o_rx_block_lock,
    output logic                 o_serdes_rx_bitslip
);

    localparam int unsigned SH_W   = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
    localparam int unsigned INV_W  = $clog2(ERR_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_TEST      = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               lock_q, lock_d;
    logic               slip_q, slip_d;

    logic hdr_good;
    logic window_end;
    logic err_limit_hit;

    // A sync header is valid when its two bits differ (01 or 10).
    assign hdr_good      = ^i_serdes_rx_hdr[1:0];
    assign window_end    = (sh_cnt_q == SH_W'(LOCK_CNT - 1));
    assign err_limit_hit = !hdr_good && (inv_cnt_q == INV_W'(ERR_LIMIT - 1));

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_TEST: begin
                if (i_serdes_rx_hdr_valid) begin
                    if (!hdr_good) begin
                        state_d    = ST_SLIP_WAIT;
                        sh_cnt_d   = '0;
                        wait_cnt_d = WAIT_W'(SLIP_WAIT_CYCLES);
                    end else if (window_end) begin
                        state_d   = ST_LOCKED;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SH_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (i_serdes_rx_hdr_valid) begin
                    if (err_limit_hit) begin
                        state_d    = ST_SLIP_WAIT;
                        sh_cnt_d   = '0;
                        inv_cnt_d  = '0;
                        wait_cnt_d = WAIT_W'(SLIP_WAIT_CYCLES);
                    end else if (window_end) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d  = sh_cnt_q + SH_W'(1);
                        inv_cnt_d = inv_cnt_q + INV_W'(!hdr_good);
                    end
                end
            end
            ST_SLIP_WAIT: begin
                if (wait_cnt_q == WAIT_W'(1)) begin
                    state_d  = ST_TEST;
                    sh_cnt_d = '0;
                end
                wait_cnt_d = wait_cnt_q - WAIT_W'(1);
            end
            default: begin
                state_d    = ST_TEST;
                sh_cnt_d   = '0;
                inv_cnt_d  = '0;
                wait_cnt_d = '0;
            end
        endcase

        // Lock mirrors the next state; bitslip marks entry into the wait state.
        lock_d = (state_d == ST_LOCKED);
        slip_d = (state_d == ST_SLIP_WAIT) && (state_q != ST_SLIP_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_TEST;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
        end
    end

    assign o_rx_block_lock     = lock_q;
    assign o_serdes_rx_bitslip = slip_q;

`ifdef RX_LOCK_STATS_EN
    logic [15:0] slip_cnt_q;
    logic [15:0] lock_loss_cnt_q;
    logic        lock_loss_ev;

    assign lock_loss_ev = (state_q == ST_LOCKED) && (state_d == ST_SLIP_WAIT);

    // Saturating event counters, updated alongside the registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            slip_cnt_q      <= '0;
            lock_loss_cnt_q <= '0;
        end else begin
            if (slip_d && (slip_cnt_q != 16'hFFFF))
                slip_cnt_q <= slip_cnt_q + 16'd1;
            if (lock_loss_ev && (lock_loss_cnt_q != 16'hFFFF))
                lock_loss_cnt_q <= lock_loss_cnt_q + 16'd1;
        end
    end

    assign o_slip_cnt      = slip_cnt_q;
    assign o_lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: tb/tb_eth_phy_10g_rx_block_lock_ctrl.sv
// Scoreboard bench for eth_phy_10g_rx_block_lock_ctrl; a behavioural model queues expected outputs per cycle.
module tb_eth_phy_10g_rx_block_lock_ctrl;

    localparam int LOCK_CNT  = 64;
    localparam int ERR_LIMIT = 16;
    localparam int SW_CYC    = 32;

    typedef struct {
        logic        lock;
        logic        slip;
        logic [15:0] slips;
        logic [15:0] losses;
    } exp_t;

    logic       clk_tb = 1'b0;
    logic       rx_rst_tb;
    logic [1:0] hdr;
    logic       hdr_valid;
    logic       rx_block_lock;
    logic       serdes_rx_bitslip;
`ifdef RX_LOCK_STATS_EN
    logic [15:0] slip_cnt;
    logic [15:0] lock_loss_cnt;
`endif

    eth_phy_10g_rx_block_lock_ctrl dut (
        .clk                   (clk_tb),
        .rst                   (rx_rst_tb),
        .i_serdes_rx_hdr       (hdr),
        .i_serdes_rx_hdr_valid (hdr_valid),
`ifdef RX_LOCK_STATS_EN
        .o_slip_cnt            (slip_cnt),
        .o_lock_loss_cnt       (lock_loss_cnt),
`endif
        .o_rx_block_lock       (rx_block_lock),
        .o_serdes_rx_bitslip   (serdes_rx_bitslip)
    );

    always #5 clk_tb = ~clk_tb;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb_q[$];

    // Reference model state: 0 = test, 1 = locked, 2 = slip wait.
    int m_state = 0, m_good = 0, m_bad = 0, m_wait = 0;
    int m_slips = 0, m_losses = 0;
    logic m_lock = 1'b0, m_slip = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model(input logic r, input logic [1:0] h, input logic v);
        bit bad;
        bad    = (h == 2'b00) || (h == 2'b11);
        m_slip = 1'b0;
        if (r) begin
            m_state = 0; m_good = 0; m_bad = 0; m_wait = 0;
            m_slips = 0; m_losses = 0;
        end else if (m_state == 0) begin
            if (v && bad) begin
                m_state = 2; m_wait = SW_CYC; m_good = 0; m_slip = 1'b1; m_slips++;
            end else if (v) begin
                m_good++;
                if (m_good == LOCK_CNT) begin
                    m_state = 1; m_good = 0; m_bad = 0;
                end
            end
        end else if (m_state == 1) begin
            if (v) begin
                m_good++;
                if (bad) m_bad++;
                if (m_bad == ERR_LIMIT) begin
                    m_state = 2; m_wait = SW_CYC; m_good = 0; m_bad = 0;
                    m_slip = 1'b1; m_slips++; m_losses++;
                end else if (m_good == LOCK_CNT) begin
                    m_good = 0; m_bad = 0;
                end
            end
        end else begin
            m_wait--;
            if (m_wait == 0) begin
                m_state = 0; m_good = 0;
            end
        end
        if (m_slips > 16'hFFFF) m_slips = 16'hFFFF;
        if (m_losses > 16'hFFFF) m_losses = 16'hFFFF;
        m_lock = (m_state == 1);
    endtask

    // One clock: drive inputs, queue the model's expectation, compare after the edge.
    task automatic step(input logic r, input logic [1:0] h, input logic v);
        exp_t e;
        rx_rst_tb = r; hdr = h; hdr_valid = v;
        model(r, h, v);
        e.lock = m_lock; e.slip = m_slip;
        e.slips = 16'(m_slips); e.losses = 16'(m_losses);
        sb_q.push_back(e);
        @(posedge clk_tb);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("lock", 32'(rx_block_lock), 32'(e.lock));
        check("bitslip", 32'(serdes_rx_bitslip), 32'(e.slip));
        check("no_lock_and_slip", 32'(rx_block_lock & serdes_rx_bitslip), 32'd0);
`ifdef RX_LOCK_STATS_EN
        check("slip_cnt", 32'(slip_cnt), 32'(e.slips));
        check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.losses));
`endif
    endtask

    // Runs until lock is seen, returning the number of clocks taken (bounded).
    task automatic run_until_lock(input logic [1:0] h, input bit toggle, output int n, output int slips);
        n = 0; slips = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b0, h, toggle ? ((i % 2) == 0) : 1'b1);
            n++;
            if (serdes_rx_bitslip) slips++;
            if (rx_block_lock) break;
        end
        check("lock_reached", 32'(rx_block_lock), 32'd1);
    endtask

    initial begin
        int n, s, last, first;
        rx_rst_tb = 1'b1; hdr = 2'b11; hdr_valid = 1'b1;

        // 1: long reset with invalid headers present
        for (int i = 0; i < 100; i++) step(1'b1, 2'b11, 1'b1);
        check("reset_lock", 32'(rx_block_lock), 32'd0);
        check("reset_slip", 32'(serdes_rx_bitslip), 32'd0);

        // 2: clean headers lock after exactly LOCK_CNT samples
        run_until_lock(2'b01, 1'b0, n, s);
        check("lock_latency", 32'(n), 32'd64);
        check("lock_no_slip", 32'(s), 32'd0);

        // 3: constant invalid header gives periodic bitslips
        step(1'b1, 2'b11, 1'b1);
        first = -1; last = 0; s = 0;
        for (int i = 1; i <= 400 && s < 10; i++) begin
            step(1'b0, 2'b11, 1'b1);
            if (serdes_rx_bitslip) begin
                if (s == 0) first = i;
                else check("slip_period", 32'(i - last), 32'd33);
                last = i; s++;
            end
        end
        check("first_slip_delay", 32'(first), 32'd1);
        check("slip_pulses", 32'(s), 32'd10);
`ifdef RX_LOCK_STATS_EN
        check("slip_cnt_10", 32'(slip_cnt), 32'd10);
`endif

        // 4: error tolerance inside one window, then loss and re-lock
        step(1'b1, 2'b01, 1'b1);
        run_until_lock(2'b01, 1'b0, n, s);
        for (int i = 0; i < 15; i++) step(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 49; i++) step(1'b0, 2'b01, 1'b1);
        check("lock_hold_15", 32'(rx_block_lock), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 2'b00, 1'b1);
        check("lock_lost_16", 32'(rx_block_lock), 32'd0);
        check("loss_slip", 32'(serdes_rx_bitslip), 32'd1);
`ifdef RX_LOCK_STATS_EN
        check("lock_loss_cnt_1", 32'(lock_loss_cnt), 32'd1);
`endif
        run_until_lock(2'b01, 1'b0, n, s);
        check("relock_latency", 32'(n), 32'd96);

        // 5: qualifier toggling halves the sample rate
        step(1'b1, 2'b10, 1'b1);
        run_until_lock(2'b10, 1'b1, n, s);
        check("toggle_latency", 32'(n), 32'd127);
        check("toggle_no_slip", 32'(s), 32'd0);

        // 6a: reset during slip wait
        step(1'b1, 2'b01, 1'b1);
        step(1'b0, 2'b11, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 2'b01, 1'b1);
        step(1'b1, 2'b01, 1'b1);
        check("rst_wait_lock", 32'(rx_block_lock), 32'd0);
        check("rst_wait_slip", 32'(serdes_rx_bitslip), 32'd0);
        run_until_lock(2'b01, 1'b0, n, s);
        check("rst_wait_relock", 32'(n), 32'd64);

        // 6b: reset mid locked window with errors pending
        for (int i = 0; i < 10; i++) step(1'b0, (i % 2) ? 2'b11 : 2'b10, 1'b1);
        check("mid_window_lock", 32'(rx_block_lock), 32'd1);
        step(1'b1, 2'b01, 1'b1);
        check("rst_lock_lock", 32'(rx_block_lock), 32'd0);
        check("rst_lock_slip", 32'(serdes_rx_bitslip), 32'd0);
        run_until_lock(2'b01, 1'b0, n, s);
        check("rst_lock_relock", 32'(n), 32'd64);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
